// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline control bundle: hazard/handshake inputs from the datapath and the
// per-latch load/flush controls returned to it.
interface pipeline_hazard_ctrl_if;
  // Decode-stage sources and ID/EX latch control word
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_uses_rs1;
  logic       id_uses_rs2;
  logic [4:0] ex_rd;
  logic       ex_is_load;
  logic       ex_br_taken;
  // Memory handshakes
  logic       imem_read;
  logic       imem_resp;
  logic       dmem_read;
  logic       dmem_write;
  logic       dmem_resp;
  // Latch controls
  logic       pc_load;
  logic       if_id_load;
  logic       id_ex_load;
  logic       ex_mem_load;
  logic       mem_wb_load;
  logic       if_id_flush;
  logic       id_ex_flush;
  logic       ex_mem_flush;
  logic       mem_wb_flush;

  // Datapath side: reports hazards and handshakes, obeys the latch controls
  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_is_load,
           ex_br_taken, imem_read, imem_resp, dmem_read, dmem_write, dmem_resp,
    input  pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load,
           if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush
  );

  // Control unit side
  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_is_load,
           ex_br_taken, imem_read, imem_resp, dmem_read, dmem_write, dmem_resp,
    output pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load,
           if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, memory-wait freeze and
// wrong-path squash for a 5-stage pipeline, with a condition FSM and
// wrapping stall-statistics counters.
module pipeline_hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  pipeline_hazard_ctrl_if.slave bus,
  input  logic                perf_clear,
  output logic [1:0]          ctrl_state,
  output logic [CNT_W-1:0]    perf_cycles,
  output logic [CNT_W-1:0]    perf_mem_stall,
  output logic [CNT_W-1:0]    perf_bubble,
  output logic [CNT_W-1:0]    perf_redirect
);

  // The state value doubles as the action taken in the cycle that enters it.
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_BUBBLE   = 2'd2,
    ST_REDIRECT = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic mem_stall;
  logic lu_hazard;

  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic [CNT_W-1:0] mem_stall_cnt_q, mem_stall_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic [CNT_W-1:0] redirect_cnt_q, redirect_cnt_d;

  logic [4:0] loads;    // {pc, if_id, id_ex, ex_mem, mem_wb}
  logic [3:0] flushes;  // {if_id, id_ex, ex_mem, mem_wb}

  // Hazard detection; x0 is hard-wired zero so it never creates a dependency
  always_comb begin
    mem_stall = (bus.imem_read & ~bus.imem_resp) |
                ((bus.dmem_read | bus.dmem_write) & ~bus.dmem_resp);
    lu_hazard = bus.ex_is_load && (bus.ex_rd != 5'd0) &&
                ((bus.id_uses_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                 (bus.id_uses_rs2 && (bus.id_rs2 == bus.ex_rd)));
  end

  // Next state: the action chosen this cycle, by priority
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d = ST_RUN;
    if (rst)              state_d = ST_RUN;
    else if (mem_stall)   state_d = ST_MEM_WAIT;   // freeze holds any pending redirect/hazard
    else if (bus.ex_br_taken) state_d = ST_REDIRECT; // wrong-path ID instruction is squashed
    else if (lu_hazard)   state_d = ST_BUBBLE;
    else                  state_d = ST_RUN;
  end

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  // Latch controls: combinational from this cycle's action so they act on this edge
  always_comb begin
    loads   = 5'b11111;
    flushes = 4'b0000;
    if (rst) begin
      loads   = 5'b00000;
      flushes = 4'b1111;
    end else begin
      unique case (state_d)
        ST_MEM_WAIT: begin
          loads   = 5'b00000;
          flushes = 4'b0000;
        end
        ST_REDIRECT: begin
          loads   = 5'b11111;
          flushes = 4'b1100;
        end
        ST_BUBBLE: begin
          // Hold PC and IF/ID, push a bubble into ID/EX, let EX/MEM/WB drain
          loads   = 5'b00111;
          flushes = 4'b0100;
        end
        default: begin
          loads   = 5'b11111;
          flushes = 4'b0000;
        end
      endcase
    end
  end

  assign bus.pc_load      = loads[4];
  assign bus.if_id_load   = loads[3];
  assign bus.id_ex_load   = loads[2];
  assign bus.ex_mem_load  = loads[1];
  assign bus.mem_wb_load  = loads[0];
  assign bus.if_id_flush  = flushes[3];
  assign bus.id_ex_flush  = flushes[2];
  assign bus.ex_mem_flush = flushes[1];
  assign bus.mem_wb_flush = flushes[0];

  // Counter next values: wrap naturally, clear overrides the increment
  always_comb begin
    cycles_d        = cycles_q + CNT_W'(1);
    mem_stall_cnt_d = mem_stall_cnt_q + ((state_d == ST_MEM_WAIT) ? CNT_W'(1) : CNT_W'(0));
    bubble_cnt_d    = bubble_cnt_q    + ((state_d == ST_BUBBLE)   ? CNT_W'(1) : CNT_W'(0));
    redirect_cnt_d  = redirect_cnt_q  + ((state_d == ST_REDIRECT) ? CNT_W'(1) : CNT_W'(0));
    if (perf_clear) begin
      cycles_d        = '0;
      mem_stall_cnt_d = '0;
      bubble_cnt_d    = '0;
      redirect_cnt_d  = '0;
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cycles_q        <= '0;
      mem_stall_cnt_q <= '0;
      bubble_cnt_q    <= '0;
      redirect_cnt_q  <= '0;
    end else begin
      cycles_q        <= cycles_d;
      mem_stall_cnt_q <= mem_stall_cnt_d;
      bubble_cnt_q    <= bubble_cnt_d;
      redirect_cnt_q  <= redirect_cnt_d;
    end
  end

  assign ctrl_state     = state_q;
  assign perf_cycles    = cycles_q;
  assign perf_mem_stall = mem_stall_cnt_q;
  assign perf_bubble    = bubble_cnt_q;
  assign perf_redirect  = redirect_cnt_q;

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Pipeline control unit that drives the `load` and `flush` inputs of every inter-stage latch: IF/ID, ID/EX (decode latch), EX/MEM and MEM/WB. It also drives the PC load.
- Inputs come from the decode stage (source registers) and the ID/EX latch outputs (destination register, load flag, branch resolution). It also sees the instruction- and data-memory handshakes.
- It inserts load-use bubbles, freezes the pipeline on memory wait, and squashes wrong-path instructions on a taken branch or jump.
- A small FSM records the pipeline condition, and saturation-free performance counters expose stall statistics.

## Interface
- `CNT_W`, default 32: width of each performance counter.
- `clk` in 1: pipeline clock, rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `id_rs1`, `id_rs2` in 5 each: source register indices of the instruction in ID.
- `id_uses_rs1`, `id_uses_rs2` in 1 each: the instruction in ID actually reads that source.
- `ex_rd` in 5: destination register of the instruction in EX, taken from the ID/EX latch control word.
- `ex_is_load` in 1: the instruction in EX is a load.
- `ex_br_taken` in 1: the branch or jump in EX resolved as a redirect this cycle.
- `imem_read` and `imem_resp` in 1 each: the IF request is active, and its data is valid.
- `dmem_read`, `dmem_write` and `dmem_resp` in 1 each: the MEM-stage access is active, and it has completed.
- `perf_clear` in 1: synchronous clear of all counters.
- `pc_load`, `if_id_load`, `id_ex_load`, `ex_mem_load` and `mem_wb_load` out 1 each.
- `if_id_flush`, `id_ex_flush`, `ex_mem_flush` and `mem_wb_flush` out 1 each.
  - Each flush clears its latch to a bubble (all-zero control word) on the next edge.
  - Flush dominates load.
- `ctrl_state` out 2: FSM state, encoded RUN=0, MEM_WAIT=1, BUBBLE=2, REDIRECT=3.
- `perf_cycles`, `perf_mem_stall`, `perf_bubble` and `perf_redirect` out CNT_W each.

## Operation
- Load and flush outputs are combinational from the inputs of the current cycle, so they act on the same edge. The FSM and the counters are registered.
- `mem_stall` = (`imem_read` & !`imem_resp`) | ((`dmem_read` | `dmem_write`) & !`dmem_resp`).
- `lu_hazard` = `ex_is_load` & (`ex_rd` != 0) & ((`id_uses_rs1` & `id_rs1`==`ex_rd`) | (`id_uses_rs2` & `id_rs2`==`ex_rd`)).
- Action priority, highest first:
  1. `rst`: all loads 0, all four flushes 1.
  2. `mem_stall`: all loads 0, all flushes 0. The whole pipeline freezes, and a pending `ex_br_taken` or `lu_hazard` is held in place.
  3. `ex_br_taken`: all loads 1, `if_id_flush`=1, `id_ex_flush`=1, the other flushes 0. The PC takes the branch target.
  4. `lu_hazard`: `pc_load`=0 and `if_id_load`=0, so the instruction is held in IF/ID. `id_ex_load`=1 with `id_ex_flush`=1, which inserts a bubble. `ex_mem_load`=1 and `mem_wb_load`=1.
  5. Otherwise: all loads 1, all flushes 0.
- Redirect beats load-use: the ID instruction is wrong-path and is squashed.
- Register x0 never creates a hazard.
- FSM next state equals the action taken this cycle: MEM_WAIT for action 2, REDIRECT for 3, BUBBLE for 4, RUN for 5. Reset forces RUN.
- Counters:
  - `perf_cycles` increments every non-reset cycle.
  - `perf_mem_stall`, `perf_redirect` and `perf_bubble` increment on cycles taking action 2, 3 and 4 respectively.
  - All counters wrap modulo 2^CNT_W.
  - `perf_clear` zeroes all counters at the edge, overriding that cycle's increment.

## Timing
- Reset values: `ctrl_state`=RUN and all counters 0. Outputs while `rst`=1 follow action 1.
- The first cycle after reset deassertion is evaluated normally.
- Load-use costs exactly 1 bubble cycle. In the following cycle the load has moved to MEM, `ex_is_load` becomes 0, and the instruction in ID advances.
- Redirect penalty is 2 squashed instructions (IF/ID and ID/EX contents).
- Memory wait adds N frozen cycles for N cycles of missing response. The cycle in which `resp` rises is not a stall cycle.
- `ex_br_taken` during a stall: no flush occurs until the first non-stall cycle. The redirect then executes exactly once.
- A reset asserted mid-stall or mid-bubble clears all latches. The FSM returns to RUN on the next edge.

## Test plan
- Load-use:
  - Stimulus: `ex_is_load`=1, `ex_rd`=5, `id_rs1`=5, `id_uses_rs1`=1 for one cycle.
  - Required: `pc_load`=0, `if_id_load`=0, `id_ex_flush`=1. Next `ctrl_state`=2 and `perf_bubble`=1.
- x0 and unused source:
  - Stimulus: `ex_rd`=0 with matching `id_rs1`. Separately, `id_rs2`=`ex_rd`=7 with `id_uses_rs2`=0.
  - Required: both cases take the RUN action, with all loads 1.
- Redirect:
  - Stimulus: `ex_br_taken`=1 together with a concurrent `lu_hazard`.
  - Required: all loads 1, `if_id_flush`=`id_ex_flush`=1, `ex_mem_flush`=0, `perf_redirect`=1, `perf_bubble` unchanged.
- Data-memory wait:
  - Stimulus: `dmem_read`=1 with `dmem_resp` low for 3 cycles, `ex_br_taken`=1 throughout, then `resp` high.
  - Required: 3 frozen cycles with all outputs 0 and `perf_mem_stall`=3. A single redirect follows on the `resp` cycle.
- Reset mid-stall:
  - Stimulus: `rst`=1 during MEM_WAIT.
  - Required: all flushes 1 and loads 0. Next `ctrl_state`=0 and all counters 0.
- Counter wrap and clear:
  - Stimulus: CNT_W=4, run 17 cycles, then `perf_clear` together with a stall.
  - Required: `perf_cycles`=1 after 17 cycles. After the clear edge, all counters read 0.
